// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART path.
//   parity_e   : parity mode encoding (none / odd / even)
//   tx_state_e : transmitter FSM states
//   frame_bits : total serial bits in one frame for a given configuration
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick marks the last
// cycle of each bit period. restart holds the count at 0 so the next period
// starts cleanly (the receiver will use it to realign on a half-bit).
//   clk     : clock
//   rst     : synchronous active-high reset
//   restart : force count to 0 (suppresses tick)
//   tick    : one-cycle pulse when the count is CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses nonblocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter with a one-word holding buffer. Frame: start (0), data LSB
// first, optional parity, STOP_BITS stop bits (1). The line idles high.
//   clk      : clock
//   rst      : synchronous active-high reset; aborts any frame, drops held word
//   tx_data  : word to send, sampled when tx_valid && tx_ready
//   tx_valid : producer offers tx_data
//   tx_ready : holding buffer empty
//   tx_out   : registered serial output
//   busy     : frame on the line or word held
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy
);

    // ---------------- parameter legality ----------------
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam parity_e          PAR_MODE   = parity_e'(PARITY[1:0]);
    localparam bit               HAS_PARITY = (PAR_MODE != PAR_NONE);
    localparam int               IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx_out;

    logic w_tick;
    logic w_restart;
    logic w_load_par;
    logic w_line;

    // Counter held at 0 while idle, so START always gets a full bit period.
    // Other state entries coincide with a wrap, which also lands on 0.
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

    // Parity comes from the held word as it enters the shifter, because the
    // shifter copy is destroyed bit by bit during DATA.
    assign w_load_par = (PAR_MODE == PAR_ODD) ? ~^r_buf : ^r_buf;

    // Line level for the current state; registered below into tx_out.
    always_comb begin
        // NOTE: default first so every path assigns w_line and no latch forms.
        w_line = 1'b1;
        case (r_state)
            ST_START:  w_line = 1'b0;
            ST_DATA:   w_line = r_shift[0];
            ST_PARITY: w_line = r_par_bit;
            default:   w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_bit_idx  <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_out <= w_line;

            // Accept only into an empty buffer; the load paths below empty it
            // only when it was full, so the two never collide.
            if (tx_valid && !r_buf_full) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_buf_full) begin
                        r_shift    <= r_buf;
                        r_par_bit  <= w_load_par;
                        r_buf_full <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= '0;
                            // Chain straight into the next start bit when a
                            // word is waiting: zero idle gap between frames.
                            if (r_buf_full) begin
                                r_shift    <= r_buf;
                                r_par_bit  <= w_load_par;
                                r_buf_full <= 1'b0;
                                r_state    <= ST_START;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_ready = !r_buf_full;
    assign busy     = r_buf_full || (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Five uart_tx instances in different configurations share clk/rst:
//   0: 8N1 /4   1: 8E1 /4   2: 8O1 /4   3: 5N2 /2   4: 7O2 /2 (random stream)
// Expected line waveforms are built from the frame rules (bit list, each bit
// repeated CLKS_PER_BIT times). The stream instance is checked by a decoding
// monitor against a queue of accepted words.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NI = 5;
    localparam int CFG_C  [NI] = '{4, 4, 4, 2, 2};
    localparam int CFG_DB [NI] = '{8, 8, 8, 5, 7};
    localparam int CFG_PAR[NI] = '{0, 2, 1, 0, 1};
    localparam int CFG_SB [NI] = '{1, 1, 1, 2, 2};
    localparam int NSTREAM = 100;

    logic       clk;
    logic       rst;
    logic [8:0] tx_data_a [NI];
    logic       tx_valid_a[NI];
    logic       tx_ready_a[NI];
    logic       tx_out_a  [NI];
    logic       busy_a    [NI];

    int n_checks;
    int n_errors;
    int exp_q[$];

    uart_tx #(.CLKS_PER_BIT(CFG_C[0]), .DATA_BITS(CFG_DB[0]), .PARITY(CFG_PAR[0]), .STOP_BITS(CFG_SB[0])) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data_a[0][7:0]), .tx_valid(tx_valid_a[0]),
        .tx_ready(tx_ready_a[0]), .tx_out(tx_out_a[0]), .busy(busy_a[0]));
    uart_tx #(.CLKS_PER_BIT(CFG_C[1]), .DATA_BITS(CFG_DB[1]), .PARITY(CFG_PAR[1]), .STOP_BITS(CFG_SB[1])) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data_a[1][7:0]), .tx_valid(tx_valid_a[1]),
        .tx_ready(tx_ready_a[1]), .tx_out(tx_out_a[1]), .busy(busy_a[1]));
    uart_tx #(.CLKS_PER_BIT(CFG_C[2]), .DATA_BITS(CFG_DB[2]), .PARITY(CFG_PAR[2]), .STOP_BITS(CFG_SB[2])) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data_a[2][7:0]), .tx_valid(tx_valid_a[2]),
        .tx_ready(tx_ready_a[2]), .tx_out(tx_out_a[2]), .busy(busy_a[2]));
    uart_tx #(.CLKS_PER_BIT(CFG_C[3]), .DATA_BITS(CFG_DB[3]), .PARITY(CFG_PAR[3]), .STOP_BITS(CFG_SB[3])) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data_a[3][4:0]), .tx_valid(tx_valid_a[3]),
        .tx_ready(tx_ready_a[3]), .tx_out(tx_out_a[3]), .busy(busy_a[3]));
    uart_tx #(.CLKS_PER_BIT(CFG_C[4]), .DATA_BITS(CFG_DB[4]), .PARITY(CFG_PAR[4]), .STOP_BITS(CFG_SB[4])) u4 (
        .clk(clk), .rst(rst), .tx_data(tx_data_a[4][6:0]), .tx_valid(tx_valid_a[4]),
        .tx_ready(tx_ready_a[4]), .tx_out(tx_out_a[4]), .busy(busy_a[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_cycles(input int idx);
        return frame_bits(CFG_DB[idx], CFG_PAR[idx], CFG_SB[idx]) * CFG_C[idx];
    endfunction

    // Expected line level per cycle from the first start-bit cycle.
    function automatic logic [127:0] exp_wave(input int idx, input int word);
        int           bits[$];
        int           ones;
        logic [127:0] w;
        bits.push_back(0);
        for (int i = 0; i < CFG_DB[idx]; i++) bits.push_back((word >> i) & 1);
        ones = $countones(word & ((1 << CFG_DB[idx]) - 1));
        if (CFG_PAR[idx] == 2) bits.push_back(ones % 2);
        if (CFG_PAR[idx] == 1) bits.push_back(1 - (ones % 2));
        for (int i = 0; i < CFG_SB[idx]; i++) bits.push_back(1);
        w = '0;
        for (int b = 0; b < bits.size(); b++)
            for (int k = 0; k < CFG_C[idx]; k++)
                w[b * CFG_C[idx] + k] = (bits[b] != 0);
        return w;
    endfunction

    // Single frame from an idle transmitter; checks latency, waveform, busy.
    task automatic send_frame(input int idx, input int word, input string tag);
        int           n;
        logic [127:0] obs;
        logic [127:0] obs_busy;
        logic [127:0] exp_busy;
        n = frame_cycles(idx);
        @(negedge clk);
        check($sformatf("%s_ready_pre", tag), tx_ready_a[idx], 1'b1);
        tx_data_a[idx]  = word[8:0];
        tx_valid_a[idx] = 1'b1;
        @(negedge clk);  // after handshake edge k
        tx_valid_a[idx] = 1'b0;
        check($sformatf("%s_busy_k", tag), busy_a[idx], 1'b1);
        check($sformatf("%s_ready_k", tag), tx_ready_a[idx], 1'b0);
        check($sformatf("%s_line_k", tag), tx_out_a[idx], 1'b1);
        @(negedge clk);  // after edge k+1: word in shifter, line not yet low
        check($sformatf("%s_ready_k1", tag), tx_ready_a[idx], 1'b1);
        check($sformatf("%s_line_k1", tag), tx_out_a[idx], 1'b1);
        obs = '0; obs_busy = '0; exp_busy = '0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            obs[j]      = tx_out_a[idx];
            obs_busy[j] = busy_a[idx];
            exp_busy[j] = (j < n - 1);
        end
        check($sformatf("%s_wave", tag), obs, exp_wave(idx, word));
        check($sformatf("%s_busy_wave", tag), obs_busy, exp_busy);
        @(negedge clk);
        check($sformatf("%s_idle_after", tag), tx_out_a[idx], 1'b1);
    endtask

    task automatic back_to_back();
        int           n;
        logic [127:0] obs_line, exp_line, obs_rdy, exp_rdy;
        int           zeros;
        n = frame_cycles(0);
        @(negedge clk);
        check("b2b_ready_pre", tx_ready_a[0], 1'b1);
        tx_data_a[0] = 9'h0A5; tx_valid_a[0] = 1'b1;
        @(negedge clk);  // after k
        check("b2b_ready_k", tx_ready_a[0], 1'b0);
        tx_data_a[0] = 9'h03C;
        @(negedge clk);  // after k+1: buffer free, 0x3C taken at k+2
        check("b2b_ready_k1", tx_ready_a[0], 1'b1);
        exp_line = exp_wave(0, 'hA5) | (exp_wave(0, 'h3C) << n);
        obs_line = '0; obs_rdy = '0; exp_rdy = '0;
        for (int j = 0; j < 2 * n; j++) begin
            @(negedge clk);
            if (j == 0) tx_data_a[0] = 9'h096;  // third word, must stall
            obs_line[j] = tx_out_a[0];
            obs_rdy[j]  = tx_ready_a[0];
            exp_rdy[j]  = (j >= n - 1);
            if (tx_ready_a[0]) tx_valid_a[0] = 1'b0;
        end
        check("b2b_wave", obs_line, exp_line);
        check("b2b_ready_wave", obs_rdy, exp_rdy);
        check("b2b_busy_end", busy_a[0], 1'b0);
        zeros = 0;
        repeat (3 * n) begin
            @(negedge clk);
            if (tx_out_a[0] == 1'b0) zeros++;
        end
        check("b2b_no_third", zeros, 0);
    endtask

    task automatic reset_mid_frame();
        int           zeros, busies;
        logic [127:0] w;
        int           n;
        n = frame_cycles(0);
        w = exp_wave(0, 'hC3);
        @(negedge clk);
        tx_data_a[0] = 9'h0C3; tx_valid_a[0] = 1'b1;
        @(negedge clk);  // after k; offer a word to be held
        tx_data_a[0] = 9'h05A;
        @(negedge clk);  // after k+1
        @(negedge clk);  // after k+2: line cycle 0, 0x5A held
        tx_valid_a[0] = 1'b0;
        check("rmf_held", tx_ready_a[0], 1'b0);
        repeat (17) @(negedge clk);  // line cycle 17 = data bit 3
        check("rmf_bit3", tx_out_a[0], w[17]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmf_line", tx_out_a[0], 1'b1);
        check("rmf_ready", tx_ready_a[0], 1'b1);
        check("rmf_busy", busy_a[0], 1'b0);
        zeros = 0; busies = 0;
        repeat (3 * n) begin
            @(negedge clk);
            if (tx_out_a[0] == 1'b0) zeros++;
            if (busy_a[0]) busies++;
        end
        check("rmf_quiet_line", zeros, 0);
        check("rmf_quiet_busy", busies, 0);
    endtask

    task automatic reset_handshake();
        int zeros;
        @(negedge clk);
        rst = 1'b1;
        tx_data_a[3] = 9'h015; tx_valid_a[3] = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_valid_a[3] = 1'b0;
        check("rhs_ready", tx_ready_a[3], 1'b1);
        check("rhs_busy", busy_a[3], 1'b0);
        zeros = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_out_a[3] == 1'b0) zeros++;
        end
        check("rhs_quiet", zeros, 0);
    endtask

    task automatic stream_drive();
        int   w, waited;
        logic acc;
        for (int i = 0; i < NSTREAM; i++) begin
            w = int'($urandom_range(0, 127));
            tx_data_a[4]  = w[8:0];
            tx_valid_a[4] = 1'b1;
            acc = 1'b0; waited = 0;
            while (!acc && waited < 1000) begin
                acc = tx_ready_a[4];  // ready now => handshake at next edge
                @(negedge clk);
                waited++;
            end
            if (!acc) begin
                check("stream_accept_timeout", 0, 1);
                break;
            end
            exp_q.push_back(w);
            if ($urandom_range(0, 7) == 0) begin
                tx_valid_a[4] = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end
        end
        tx_valid_a[4] = 1'b0;
    endtask

    task automatic stream_monitor();
        int   nb, c, waited, data, ones, expw;
        logic v, ok;
        nb = frame_bits(CFG_DB[4], CFG_PAR[4], CFG_SB[4]);
        c  = CFG_C[4];
        for (int f = 0; f < NSTREAM; f++) begin
            waited = 0;
            @(negedge clk);
            while (tx_out_a[4] == 1'b1 && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 2000) begin
                check("stream_start_timeout", 0, 1);
                break;
            end
            ok = 1'b1; data = 0; v = 1'b0;
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < c; k++) begin
                    if (!(b == 0 && k == 0)) @(negedge clk);
                    if (k == 0) v = tx_out_a[4];
                    else if (tx_out_a[4] !== v) ok = 1'b0;  // bit width wrong
                end
                if (b == 0) begin
                    if (v !== 1'b0) ok = 1'b0;
                end else if (b <= CFG_DB[4]) begin
                    data = data | (int'(v) << (b - 1));
                end else if (b == CFG_DB[4] + 1 && CFG_PAR[4] != 0) begin
                    ones = $countones(data);
                    if (int'(v) != ((CFG_PAR[4] == 2) ? ones % 2 : 1 - ones % 2)) ok = 1'b0;
                end else if (v !== 1'b1) begin
                    ok = 1'b0;
                end
            end
            expw = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check($sformatf("stream_data_%0d", f), data, expw);
            check($sformatf("stream_format_%0d", f), ok, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            tx_data_a[i]  = '0;
            tx_valid_a[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_line%0d", i), tx_out_a[i], 1'b1);
            check($sformatf("rst_ready%0d", i), tx_ready_a[i], 1'b1);
            check($sformatf("rst_busy%0d", i), busy_a[i], 1'b0);
        end

        send_frame(0, 'h55, "basic_55");
        for (int i = 0; i < 3; i++) send_frame(0, int'($urandom_range(0, 255)), $sformatf("rand8n1_%0d", i));
        send_frame(1, 'h03, "even_03");
        send_frame(1, 'h07, "even_07");
        send_frame(2, 'h03, "odd_03");
        send_frame(2, 'h07, "odd_07");
        send_frame(3, 'h1FF, "5n2_1f");
        back_to_back();
        reset_mid_frame();
        reset_handshake();

        fork
            stream_drive();
            stream_monitor();
        join
        check("stream_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
